// File: rtl/cu_fdxw_seq.sv
// Instruction-cycle sequencer: fetch -> decode -> execute/memory -> writeback with
// per-unit chip-select/ready handshakes, halt detection, ready timeout and retire counter.
module cu_fdxw_seq #(
  parameter int WAIT_MAX = 16,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             ready_fcu,
  input  logic             ready_dec,
  input  logic             ready_alu,
  input  logic             ready_mem,
  input  logic             dec_halt,
  input  logic             dec_mem,
  input  logic             dec_wb,
  output logic             cs_fcu,
  output logic             sel_fcu,
  output logic             cs_dec,
  output logic             cs_alu,
  output logic             cs_mem,
  output logic             wb_en,
  output logic             pc_inc,
  output logic             busy,
  output logic             halted,
  output logic             err,
  output logic [3:0]       state_dbg,
  output logic [CNT_W-1:0] instr_cnt
);

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    F_REQ  = 4'd1,
    F_WAIT = 4'd2,
    D_REQ  = 4'd3,
    D_WAIT = 4'd4,
    X_REQ  = 4'd5,
    X_WAIT = 4'd6,
    M_REQ  = 4'd7,
    M_WAIT = 4'd8,
    WB     = 4'd9,
    HALT   = 4'd10,
    ERR    = 4'd11
  } state_t;

  localparam int TW = (WAIT_MAX > 2) ? $clog2(WAIT_MAX) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'((WAIT_MAX == 0) ? 0 : WAIT_MAX - 1);

  state_t           state_reg, state_next;
  logic [TW-1:0]    tmo_reg, tmo_next;
  logic             wb_flag_reg, wb_flag_next;
  logic [CNT_W-1:0] instr_cnt_reg, instr_cnt_next;
  logic             expired;

  // The WAIT_MAX-th ready-less WAIT cycle traps; WAIT_MAX = 0 never traps.
  assign expired = (WAIT_MAX != 0) && (tmo_reg == TMO_LAST);

  always_comb begin
    state_next     = state_reg;
    tmo_next       = tmo_reg;
    wb_flag_next   = wb_flag_reg;
    instr_cnt_next = instr_cnt_reg;
    case (state_reg)
      IDLE:   if (start) state_next = F_REQ;
      F_REQ:  begin state_next = F_WAIT; tmo_next = '0; end
      D_REQ:  begin state_next = D_WAIT; tmo_next = '0; end
      X_REQ:  begin state_next = X_WAIT; tmo_next = '0; end
      M_REQ:  begin state_next = M_WAIT; tmo_next = '0; end
      F_WAIT: begin
        if (ready_fcu)    state_next = D_REQ;
        else if (expired) state_next = ERR;
        else              tmo_next   = tmo_reg + 1'b1;
      end
      D_WAIT: begin
        if (ready_dec) begin
          wb_flag_next = dec_wb;
          if (dec_halt)     state_next = HALT;
          else if (dec_mem) state_next = M_REQ;
          else              state_next = X_REQ;
        end
        else if (expired) state_next = ERR;
        else              tmo_next   = tmo_reg + 1'b1;
      end
      X_WAIT: begin
        if (ready_alu)    state_next = WB;
        else if (expired) state_next = ERR;
        else              tmo_next   = tmo_reg + 1'b1;
      end
      M_WAIT: begin
        if (ready_mem)    state_next = WB;
        else if (expired) state_next = ERR;
        else              tmo_next   = tmo_reg + 1'b1;
      end
      WB: begin
        state_next     = F_REQ;
        instr_cnt_next = instr_cnt_reg + CNT_W'(1);
      end
      HALT:    state_next = HALT;
      ERR:     state_next = ERR;
      default: state_next = ERR;
    endcase
  end

  // Strobes are registered from the next state so they stay a pure function of state_reg.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      tmo_reg       <= '0;
      wb_flag_reg   <= 1'b0;
      instr_cnt_reg <= '0;
      cs_fcu        <= 1'b0;
      sel_fcu       <= 1'b0;
      cs_dec        <= 1'b0;
      cs_alu        <= 1'b0;
      cs_mem        <= 1'b0;
      wb_en         <= 1'b0;
      pc_inc        <= 1'b0;
      busy          <= 1'b0;
      halted        <= 1'b0;
      err           <= 1'b0;
    end
    else begin
      state_reg     <= state_next;
      tmo_reg       <= tmo_next;
      wb_flag_reg   <= wb_flag_next;
      instr_cnt_reg <= instr_cnt_next;
      cs_fcu        <= (state_next == F_REQ);
      sel_fcu       <= (state_next == F_REQ) || (state_next == F_WAIT);
      cs_dec        <= (state_next == D_REQ);
      cs_alu        <= (state_next == X_REQ);
      cs_mem        <= (state_next == M_REQ);
      wb_en         <= (state_next == WB) && wb_flag_next;
      pc_inc        <= (state_next == WB);
      busy          <= (state_next >= F_REQ) && (state_next <= WB);
      halted        <= (state_next == HALT);
      err           <= (state_next == ERR);
    end
  end

  assign state_dbg = state_reg;
  assign instr_cnt = instr_cnt_reg;

endmodule

// File: tb/tb_cu_fdxw_seq.sv
// Directed bench for cu_fdxw_seq (WAIT_MAX=4, CNT_W=2): instruction loops, halt,
// timeout boundary, counter wrap and asynchronous reset.
module tb_cu_fdxw_seq;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       ready_fcu = 1'b0, ready_dec = 1'b0, ready_alu = 1'b0, ready_mem = 1'b0;
  logic       dec_halt = 1'b0, dec_mem = 1'b0, dec_wb = 1'b0;
  logic       cs_fcu, sel_fcu, cs_dec, cs_alu, cs_mem, wb_en, pc_inc, busy, halted, err;
  logic [3:0] state_dbg;
  logic [1:0] instr_cnt;

  int checks = 0;
  int errors = 0;

  cu_fdxw_seq #(.WAIT_MAX(4), .CNT_W(2)) dut (
    .clk(clk), .reset(reset), .start(start),
    .ready_fcu(ready_fcu), .ready_dec(ready_dec), .ready_alu(ready_alu), .ready_mem(ready_mem),
    .dec_halt(dec_halt), .dec_mem(dec_mem), .dec_wb(dec_wb),
    .cs_fcu(cs_fcu), .sel_fcu(sel_fcu), .cs_dec(cs_dec), .cs_alu(cs_alu), .cs_mem(cs_mem),
    .wb_en(wb_en), .pc_inc(pc_inc), .busy(busy), .halted(halted), .err(err),
    .state_dbg(state_dbg), .instr_cnt(instr_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
    else $display("ok   %s = %0h", tag, got);
  endtask

  // {cs_fcu,sel_fcu,cs_dec,cs_alu,cs_mem,wb_en,pc_inc,busy,halted,err} from the state table
  function automatic logic [9:0] exp_outs(input int st, input logic wb);
    case (st)
      1:       return 10'b1100000100;
      2:       return 10'b0100000100;
      3:       return 10'b0010000100;
      5:       return 10'b0001000100;
      7:       return 10'b0000100100;
      4, 6, 8: return 10'b0000000100;
      9:       return {5'b00000, wb, 4'b1100};
      10:      return 10'b0000000010;
      11:      return 10'b0000000001;
      default: return 10'b0000000000;
    endcase
  endfunction

  function automatic logic [9:0] outs();
    return {cs_fcu, sel_fcu, cs_dec, cs_alu, cs_mem, wb_en, pc_inc, busy, halted, err};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_state(input string tag, input int st, input logic wb);
    chk({tag, ".state"}, 32'(state_dbg), 32'(st));
    chk({tag, ".outs"}, 32'(outs()), 32'(exp_outs(st, wb)));
  endtask

  task automatic expect_step(input string tag, input int st, input logic wb);
    step();
    expect_state(tag, st, wb);
  endtask

  // From an F_REQ sample point, run one instruction with every ready already high.
  task automatic run_instr(input string tag, input logic mem, input logic wb);
    dec_mem = mem; dec_wb = wb; dec_halt = 1'b0;
    expect_step(tag, 2, wb);
    expect_step(tag, 3, wb);
    expect_step(tag, 4, wb);
    expect_step(tag, mem ? 7 : 5, wb);
    expect_step(tag, mem ? 8 : 6, wb);
    expect_step(tag, 9, wb);
    expect_step(tag, 1, wb);
  endtask

  task automatic reset_and_start();
    reset = 1'b0;
    step();
    reset = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset holds IDLE even with start asserted
    start = 1'b1;
    step(); step();
    expect_state("reset", 0, 1'b0);
    chk("reset.cnt", 32'(instr_cnt), 0);
    reset = 1'b1;
    step();
    start = 1'b0;
    expect_state("start", 1, 1'b0);

    ready_fcu = 1; ready_dec = 1; ready_alu = 1; ready_mem = 1;
    run_instr("alu", 1'b0, 1'b1);
    chk("alu.cnt", 32'(instr_cnt), 1);
    run_instr("mem", 1'b1, 1'b0);
    chk("mem.cnt", 32'(instr_cnt), 2);
    run_instr("alu2", 1'b0, 1'b1);
    chk("alu2.cnt", 32'(instr_cnt), 3);

    // HALT with dec_mem and dec_wb also set: halt has priority, no WB strobes
    dec_halt = 1; dec_mem = 1; dec_wb = 1;
    expect_step("halt", 2, 1'b0);
    expect_step("halt", 3, 1'b0);
    expect_step("halt", 4, 1'b0);
    expect_step("halt", 10, 1'b0);
    chk("halt.cnt", 32'(instr_cnt), 3);
    start = 1'b1;
    step(); step();
    start = 1'b0;
    expect_state("halt.start", 10, 1'b0);
    reset = 1'b0;
    #1;
    chk("halt.reset.halted", 32'(halted), 0);
    chk("halt.reset.state", 32'(state_dbg), 0);
    dec_halt = 0; dec_mem = 0; dec_wb = 0;

    // Timeout: ready_dec never arrives
    ready_dec = 1'b0;
    reset_and_start();
    expect_state("tmo", 1, 1'b0);
    expect_step("tmo", 2, 1'b0);
    expect_step("tmo", 3, 1'b0);
    expect_step("tmo.w1", 4, 1'b0);
    expect_step("tmo.w2", 4, 1'b0);
    expect_step("tmo.w3", 4, 1'b0);
    expect_step("tmo.w4", 4, 1'b0);
    expect_step("tmo.err", 11, 1'b0);
    start = 1'b1;
    expect_step("tmo.sticky", 11, 1'b0);
    start = 1'b0;

    // Ready on the 4th WAIT cycle wins over the timeout
    reset_and_start();
    expect_step("late", 2, 1'b0);
    expect_step("late", 3, 1'b0);
    expect_step("late.w1", 4, 1'b0);
    step(); step(); step();
    expect_state("late.w4", 4, 1'b0);
    ready_dec = 1'b1; dec_wb = 1'b1;
    expect_step("late.x", 5, 1'b1);
    expect_step("late", 6, 1'b1);
    expect_step("late", 9, 1'b1);
    expect_step("late", 1, 1'b1);
    chk("wrap.cnt1", 32'(instr_cnt), 1);

    run_instr("w2", 1'b0, 1'b0);
    run_instr("w3", 1'b1, 1'b1);
    chk("wrap.cnt3", 32'(instr_cnt), 3);
    run_instr("w4", 1'b0, 1'b1);
    chk("wrap.cnt0", 32'(instr_cnt), 0);
    run_instr("w5", 1'b1, 1'b0);
    chk("wrap.cnt5", 32'(instr_cnt), 1);

    // Asynchronous reset in the middle of F_WAIT
    ready_fcu = 1'b0;
    expect_step("async", 2, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    expect_state("async.reset", 0, 1'b0);
    chk("async.cnt", 32'(instr_cnt), 0);
    step();
    expect_state("async.hold", 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
